// File: rtl/kfpga_pkg.sv
// kfpga_pkg: types and constants shared by the kFPGA configuration loader.
//   loader_state_t     : loader FSM states
//   KFPGA_CHAIN_LENGTH : config chain length of the generated core (IO + logic tiles)
package kfpga_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   // Chain length of the default generated core size.
   localparam int unsigned KFPGA_CHAIN_LENGTH = 1008;

endpackage

// File: rtl/kfpga_word_serializer.sv
// kfpga_word_serializer: turns valid/ready bitstream words into a 1 bit/cycle stream, LSB first.
// Ports:
//   i_clock, i_nreset  : clock, synchronous active-low reset
//   i_run              : loader is in LOAD this cycle (shifting/accepting allowed)
//   i_run_next         : loader stays/enters LOAD next cycle; low flushes the word register
//   i_kill             : suppress any shift this cycle (abort)
//   i_final_next       : the shift of the next cycle, if any, is the last chain bit
//   i_data, i_valid    : bitstream word and its valid
//   o_ready            : registered word ready
//   o_bit, o_shift_en  : registered serial bit and shift enable for the chain
//   o_shift_c          : combinational, a bit leaves the word register this cycle
module kfpga_word_serializer #(
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  i_clock,
   input  logic                  i_nreset,
   input  logic                  i_run,
   input  logic                  i_run_next,
   input  logic                  i_kill,
   input  logic                  i_final_next,
   input  logic [WORD_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_bit,
   output logic                  o_shift_en,
   output logic                  o_shift_c
);

   localparam int unsigned CW = $clog2(WORD_WIDTH + 1);

   logic [WORD_WIDTH-1:0] r_shreg;
   logic [CW-1:0]         r_rem;
   logic                  r_ready;
   logic                  r_bit;
   logic                  r_shift_en;

   logic                  w_shift;
   logic                  w_accept;
   logic [WORD_WIDTH-1:0] w_shreg_next;
   logic [CW-1:0]         w_rem_next;
   logic                  w_ready_next;

   assign w_shift  = i_run & ~i_kill & (r_rem != '0);
   assign w_accept = i_valid & r_ready;

   // Word register next state; a new word replaces the one whose last bit leaves this cycle.
   always_comb begin
      w_shreg_next = r_shreg;
      w_rem_next   = r_rem;
      if (!i_run_next) begin
         w_shreg_next = '0;
         w_rem_next   = '0;
      end else if (w_accept) begin
         w_shreg_next = i_data;
         w_rem_next   = CW'(WORD_WIDTH);
      end else if (w_shift) begin
         w_shreg_next = r_shreg >> 1;
         w_rem_next   = r_rem - CW'(1);
      end
   end

   // Ready one cycle early when only one bit is left, unless that bit completes the chain.
   assign w_ready_next = i_run_next &
                         ((w_rem_next == '0) | ((w_rem_next == CW'(1)) & ~i_final_next));

   always_ff @(posedge i_clock) begin
      if (!i_nreset) begin
         r_shreg    <= '0;
         r_rem      <= '0;
         r_ready    <= 1'b0;
         r_bit      <= 1'b0;
         r_shift_en <= 1'b0;
      end else begin
         r_shreg    <= w_shreg_next;
         r_rem      <= w_rem_next;
         r_ready    <= w_ready_next;
         r_bit      <= w_shift & r_shreg[0];
         r_shift_en <= w_shift;
      end
   end

   assign o_ready    = r_ready;
   assign o_bit      = r_bit;
   assign o_shift_en = r_shift_en;
   assign o_shift_c  = w_shift;

endmodule

// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: loads a bitstream into the kFPGA core config chain, then releases the core.
// Ports:
//   i_clock, i_nreset        : clock (also the core config_clock), synchronous active-low reset
//   i_start, i_abort         : begin a load (IDLE/DONE only), return to IDLE (wins over start)
//   i_bs_data/valid, o_bs_ready : bitstream word stream, bit 0 shifted first
//   o_core_config_in/enable/nreset, i_core_config_out : config chain interface
//   o_core_nreset, o_core_enable : user-logic reset/enable to the core
//   o_busy, o_done, o_error  : CLEAR/LOAD, DONE, sticky chain length mismatch
module kfpga_config_loader
   import kfpga_pkg::*;
#(
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned CHAIN_LENGTH = KFPGA_CHAIN_LENGTH,
   parameter int unsigned CLEAR_CYCLES = 4
) (
   input  logic                  i_clock,
   input  logic                  i_nreset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [WORD_WIDTH-1:0] i_bs_data,
   input  logic                  i_bs_valid,
   output logic                  o_bs_ready,
   output logic                  o_core_config_in,
   input  logic                  i_core_config_out,
   output logic                  o_core_config_enable,
   output logic                  o_core_config_nreset,
   output logic                  o_core_nreset,
   output logic                  o_core_enable,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int unsigned BCW = $clog2(CHAIN_LENGTH + 1);
   localparam int unsigned CCW = $clog2(CLEAR_CYCLES + 1);

   loader_state_t  r_state;
   logic [BCW-1:0] r_bit_count;
   logic [CCW-1:0] r_clr_cnt;
   logic           r_core_config_nreset;
   logic           r_core_nreset;
   logic           r_core_enable;
   logic           r_busy;
   logic           r_done;
   logic           r_error;

   loader_state_t  w_state_next;
   logic           w_shift;
   logic           w_shift_en;
   logic           w_start_ok;
   logic           w_clear_end;
   logic           w_final;
   logic           w_final_next;
   logic           w_run;
   logic           w_run_next;
   logic           w_error_next;

   assign w_start_ok   = i_start & ~i_abort & ((r_state == IDLE) | (r_state == DONE));
   assign w_clear_end  = (r_state == CLEAR) & (r_clr_cnt == CCW'(CLEAR_CYCLES - 1));
   assign w_run        = (r_state == LOAD);
   assign w_final      = w_run & w_shift & (r_bit_count == BCW'(CHAIN_LENGTH - 1));
   assign w_run_next   = (w_state_next == LOAD);
   assign w_final_next = ((r_bit_count + BCW'(w_shift)) == BCW'(CHAIN_LENGTH - 1));

   // The chain was cleared, so any 1 at its end during a shift means it is shorter than expected.
   assign w_error_next = w_start_ok ? 1'b0 : (r_error | (w_shift_en & i_core_config_out));

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      if (i_abort) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: if (w_start_ok)  w_state_next = CLEAR;
            CLEAR:      if (w_clear_end) w_state_next = LOAD;
            LOAD:       if (w_final)     w_state_next = DONE;
            default:                     w_state_next = IDLE;
         endcase
      end
   end

   // State, counters and registered outputs (outputs follow the state being entered).
   always_ff @(posedge i_clock) begin
      if (!i_nreset) begin
         r_state              <= IDLE;
         r_bit_count          <= '0;
         r_clr_cnt            <= '0;
         r_core_config_nreset <= 1'b1;
         r_core_nreset        <= 1'b0;
         r_core_enable        <= 1'b0;
         r_busy               <= 1'b0;
         r_done               <= 1'b0;
         r_error              <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start_ok) begin
            r_bit_count <= '0;
            r_clr_cnt   <= '0;
         end else begin
            if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + CCW'(1);
            if (w_run && w_shift) r_bit_count <= r_bit_count + BCW'(1);
         end
         r_error              <= w_error_next;
         r_core_config_nreset <= (w_state_next != CLEAR);
         r_busy               <= (w_state_next == CLEAR) | (w_state_next == LOAD);
         r_done               <= (w_state_next == DONE);
         r_core_nreset        <= (w_state_next == DONE) & ~w_error_next;
         r_core_enable        <= (w_state_next == DONE) & ~w_error_next;
      end
   end

   kfpga_word_serializer #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_ser (
      .i_clock      (i_clock),
      .i_nreset     (i_nreset),
      .i_run        (w_run),
      .i_run_next   (w_run_next),
      .i_kill       (i_abort),
      .i_final_next (w_final_next),
      .i_data       (i_bs_data),
      .i_valid      (i_bs_valid),
      .o_ready      (o_bs_ready),
      .o_bit        (o_core_config_in),
      .o_shift_en   (w_shift_en),
      .o_shift_c    (w_shift)
   );

   assign o_core_config_enable = w_shift_en;
   assign o_core_config_nreset = r_core_config_nreset;
   assign o_core_nreset        = r_core_nreset;
   assign o_core_enable        = r_core_enable;
   assign o_busy               = r_busy;
   assign o_done               = r_done;
   assign o_error              = r_error;

endmodule
